neuron_sample_driver: RTL and testbench



---
 rtl/neuron_sample_driver_if.sv | 44 ++++
 rtl/neuron_sample_driver.sv | 213 +++++++++++++++++++++
 tb/tb_neuron_sample_driver.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/neuron_sample_driver_if.sv
// Sample-in stream, result-out stream and neuron core register bus of the sample driver.
// Pure wiring: no state, no latency.
// in_ready/out_ready carry the backpressure; the bus side has none (core answers in-cycle).
interface neuron_sample_driver_if #(
  parameter int Width = 32
);
  // input sample stream
  logic             in_valid;
  logic             in_ready;
  logic [Width-1:0] in_data;

  // register bus towards the neuron core
  logic             bus_write;
  logic             bus_read;
  logic [8:0]       bus_address;
  logic [Width-1:0] bus_writedata;
  logic [Width-1:0] bus_readdata;

  // result stream
  logic             out_valid;
  logic             out_ready;
  logic [Width-1:0] out_data;
  logic             out_error;

  // the driver: consumes samples, masters the bus, produces results
  modport master (
    input  in_valid, in_data,
    output in_ready,
    output bus_write, bus_read, bus_address, bus_writedata,
    input  bus_readdata,
    output out_valid, out_data, out_error,
    input  out_ready
  );

  // the surroundings: sample source, neuron core and result sink
  modport slave (
    output in_valid, in_data,
    input  in_ready,
    input  bus_write, bus_read, bus_address, bus_writedata,
    output bus_readdata,
    input  out_valid, out_data, out_error,
    output out_ready
  );
endinterface

// File: rtl/neuron_sample_driver.sv
// Streams buffered samples through the neuron core: write sample, start, poll status, read result.
// At least 5 cycles from FIFO pop to out_valid (done on first poll); back-to-back costs 2 more.
// in_ready = FIFO not full; a result is held on the output until out_ready, stalling the bus.
module neuron_sample_driver #(
  parameter int         Width      = 32,
  parameter int         FifoDepth  = 4,
  parameter logic [8:0] DataAddr   = 9'd21,
  parameter logic [8:0] StartAddr  = 9'd22,
  parameter logic [8:0] StatusAddr = 9'd23,
  parameter logic [8:0] ResultAddr = 9'd24,
  parameter int         MaxPoll    = 255
) (
  input  logic                   CLK,
  input  logic                   reset,
  neuron_sample_driver_if.master io,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int PtrW  = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int CntW  = $clog2(FifoDepth + 1);
  localparam int PollW = $clog2(MaxPoll + 1);

  localparam logic [CntW-1:0]  FifoFull = CntW'(FifoDepth);
  localparam logic [PollW-1:0] PollLast = PollW'(MaxPoll - 1);
  localparam logic [Width-1:0] StartCmd = Width'(1);

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    WR_START,
    WAIT,
    POLL,
    RD_RESULT,
    OUT_HOLD
  } state_t;

  state_t state, state_nxt;

  // ---------------------------------------------------------------------------
  // Input FIFO
  // ---------------------------------------------------------------------------
  logic [Width-1:0] fifo_mem [FifoDepth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [CntW-1:0]  count;
  logic             push;
  logic             pop;

  // Full is judged on the registered count only, so a pop in the same cycle
  // does not open the door early; this keeps in_ready free of FSM paths.
  assign io.in_ready = (count != FifoFull);
  assign push        = io.in_valid & io.in_ready;

  // FIFO pointers and occupancy; pointers wrap naturally since depth is a power of two
  always_ff @(posedge CLK) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PtrW'(1);
      if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
      case ({push, pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= io.in_data;
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  logic [PollW-1:0] poll_cnt, poll_cnt_nxt;
  logic             err_lat, err_lat_nxt;

  logic             bus_write_nxt;
  logic             bus_read_nxt;
  logic [8:0]       bus_address_nxt;
  logic [Width-1:0] bus_writedata_nxt;

  logic             out_valid_nxt;
  logic [Width-1:0] out_data_nxt;
  logic             out_error_nxt;
  logic             timeout_err_nxt;

  assign busy = (state != IDLE);

  // State register
  always_ff @(posedge CLK) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state plus next values of every registered output. Bus strobes are
  // registered, so each state schedules the strobe of the state it enters.
  always_comb begin
    state_nxt         = state;
    pop               = 1'b0;
    poll_cnt_nxt      = poll_cnt;
    err_lat_nxt       = err_lat;
    bus_write_nxt     = 1'b0;
    bus_read_nxt      = 1'b0;
    bus_address_nxt   = io.bus_address;
    bus_writedata_nxt = io.bus_writedata;
    out_valid_nxt     = io.out_valid;
    out_data_nxt      = io.out_data;
    out_error_nxt     = io.out_error;
    timeout_err_nxt   = timeout_err;

    case (state)
      IDLE: begin
        // The popped head goes straight into the write-data register, which
        // doubles as the sample register for the rest of the transaction.
        if (count != '0) begin
          pop               = 1'b1;
          state_nxt         = WR_DATA;
          bus_write_nxt     = 1'b1;
          bus_address_nxt   = DataAddr;
          bus_writedata_nxt = fifo_mem[rd_ptr];
        end
      end

      WR_DATA: begin
        state_nxt         = WR_START;
        bus_write_nxt     = 1'b1;
        bus_address_nxt   = StartAddr;
        bus_writedata_nxt = StartCmd;
      end

      WR_START: begin
        // WAIT carries no strobe: the core needs a cycle to register start
        state_nxt = WAIT;
      end

      WAIT: begin
        poll_cnt_nxt    = '0;
        state_nxt       = POLL;
        bus_read_nxt    = 1'b1;
        bus_address_nxt = StatusAddr;
      end

      POLL: begin
        if (io.bus_readdata[0]) begin
          err_lat_nxt     = io.bus_readdata[1];
          state_nxt       = RD_RESULT;
          bus_read_nxt    = 1'b1;
          bus_address_nxt = ResultAddr;
        end else if (poll_cnt == PollLast) begin
          out_valid_nxt   = 1'b1;
          out_data_nxt    = '0;
          out_error_nxt   = 1'b1;
          timeout_err_nxt = 1'b1;
          state_nxt       = OUT_HOLD;
        end else begin
          poll_cnt_nxt    = poll_cnt + PollW'(1);
          bus_read_nxt    = 1'b1;
          bus_address_nxt = StatusAddr;
        end
      end

      RD_RESULT: begin
        out_valid_nxt = 1'b1;
        out_data_nxt  = io.bus_readdata;
        out_error_nxt = err_lat;
        state_nxt     = OUT_HOLD;
      end

      OUT_HOLD: begin
        if (io.out_ready) begin
          out_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Registered bus, result and status outputs; reset abandons any transaction
  always_ff @(posedge CLK) begin
    if (!reset) begin
      poll_cnt         <= '0;
      err_lat          <= 1'b0;
      io.bus_write     <= 1'b0;
      io.bus_read      <= 1'b0;
      io.bus_address   <= '0;
      io.bus_writedata <= '0;
      io.out_valid     <= 1'b0;
      io.out_data      <= '0;
      io.out_error     <= 1'b0;
      timeout_err      <= 1'b0;
    end else begin
      poll_cnt         <= poll_cnt_nxt;
      err_lat          <= err_lat_nxt;
      io.bus_write     <= bus_write_nxt;
      io.bus_read      <= bus_read_nxt;
      io.bus_address   <= bus_address_nxt;
      io.bus_writedata <= bus_writedata_nxt;
      io.out_valid     <= out_valid_nxt;
      io.out_data      <= out_data_nxt;
      io.out_error     <= out_error_nxt;
      timeout_err      <= timeout_err_nxt;
    end
  end

endmodule

// File: tb/tb_neuron_sample_driver.sv
// Bench for neuron_sample_driver: a neuron-core responder, a transaction-level
// expectation model checked every cycle, and directed scenarios with literal results.
module tb_neuron_sample_driver;

  localparam int         W      = 32;
  localparam int         DEPTH  = 4;
  localparam int         MAXP   = 255;
  localparam logic [8:0] A_DATA = 9'd21;
  localparam logic [8:0] A_STRT = 9'd22;
  localparam logic [8:0] A_STAT = 9'd23;
  localparam logic [8:0] A_RES  = 9'd24;

  logic CLK = 1'b0;
  logic reset;
  logic busy;
  logic timeout_err;

  neuron_sample_driver_if #(.Width(W)) io ();

  neuron_sample_driver #(
    .Width(W), .FifoDepth(DEPTH), .DataAddr(A_DATA), .StartAddr(A_STRT),
    .StatusAddr(A_STAT), .ResultAddr(A_RES), .MaxPoll(MAXP)
  ) dut (
    .CLK(CLK), .reset(reset), .io(io), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  // polls = status read on which done appears (0 = never done)
  typedef struct {
    logic [W-1:0] data;
    int           polls;
    logic         err;
    logic [W-1:0] res;
  } samp_t;

  // kind: 0 no strobe, 1 write, 2 read, 3 first cycle of out_valid
  typedef struct {
    int           kind;
    logic [8:0]   addr;
    logic [W-1:0] data;
    logic         err;
    logic         tmo;
  } ev_t;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- core model
  samp_t cur;
  int    cur_reads = 0;
  samp_t act_entry;

  always @(posedge CLK) begin
    if (io.bus_write && io.bus_address == A_DATA) begin
      cur       <= act_entry;
      cur_reads <= 0;
    end else if (io.bus_read && io.bus_address == A_STAT) begin
      cur_reads <= cur_reads + 1;
    end
  end

  always_comb begin
    io.bus_readdata = 32'hDEAD_BEEF;
    if (io.bus_address == A_STAT)
      io.bus_readdata = (cur.polls != 0 && cur_reads + 1 >= cur.polls) ? {30'b0, cur.err, 1'b1} : '0;
    else if (io.bus_address == A_RES)
      io.bus_readdata = cur.res;
  end

  // ---------------------------------------------------------------- model state
  samp_t        samp_q[$];
  ev_t          exp_q[$];
  logic         chk_en       = 1'b0;
  int           clr_gen      = 0;
  int           clr_seen     = 0;
  logic         in_txn       = 1'b0;
  logic         out_pending  = 1'b0;
  logic         sticky       = 1'b0;
  logic         expect_start = 1'b0;
  logic [W-1:0] exp_out      = '0;
  logic         exp_oerr     = 1'b0;
  int           polls_seen   = 0;
  int           acc_cnt      = 0;
  int           last_polls   = 0;
  logic [W-1:0] last_out     = '0;
  logic         last_err     = 1'b0;
  int           cfg_polls    = 0;
  logic         cfg_err      = 1'b0;
  logic [W-1:0] cfg_res      = '0;
  ev_t          ev;
  samp_t        ps;
  logic         started;

  // Per-cycle bus schedule of one transaction, counted from its write@DataAddr cycle
  task automatic gen(input samp_t s);
    ev_t e;
    int  n;
    n = (s.polls == 0) ? MAXP : s.polls;
    e.kind = 1; e.addr = A_STRT; e.data = 1; e.err = 1'b0; e.tmo = 1'b0;
    exp_q.push_back(e);
    e.kind = 0;
    exp_q.push_back(e);
    for (int i = 0; i < n; i++) begin
      e.kind = 2; e.addr = A_STAT;
      exp_q.push_back(e);
    end
    if (s.polls != 0) begin
      e.kind = 2; e.addr = A_RES;
      exp_q.push_back(e);
    end
    e.kind = 3;
    e.data = (s.polls != 0) ? s.res : '0;
    e.err  = (s.polls != 0) ? s.err : 1'b1;
    e.tmo  = (s.polls == 0);
    exp_q.push_back(e);
  endtask

  // ---------------------------------------------------------------- compare process
  always @(negedge CLK) begin
    if (chk_en) begin
      if (clr_seen != clr_gen) begin
        clr_seen = clr_gen;
        samp_q.delete();
        exp_q.delete();
        in_txn = 1'b0; out_pending = 1'b0; sticky = 1'b0; expect_start = 1'b0;
      end

      if (exp_q.size() != 0) begin
        ev = exp_q.pop_front();
        chk("bus_write", 64'(io.bus_write), 64'(ev.kind == 1));
        chk("bus_read", 64'(io.bus_read), 64'(ev.kind == 2));
        if (ev.kind == 1 || ev.kind == 2) chk("bus_address", 64'(io.bus_address), 64'(ev.addr));
        if (ev.kind == 1) chk("bus_writedata", 64'(io.bus_writedata), 64'(ev.data));
        if (ev.kind == 2 && ev.addr == A_STAT) polls_seen++;
        if (ev.kind == 3) begin
          out_pending = 1'b1;
          exp_out     = ev.data;
          exp_oerr    = ev.err;
          if (ev.tmo) sticky = 1'b1;
        end
      end else begin
        started = !in_txn && io.bus_write;
        chk("txn_start", 64'(started), 64'(expect_start));
        if (started) begin
          chk("start_address", 64'(io.bus_address), 64'(A_DATA));
          chk("start_no_read", 64'(io.bus_read), 64'(0));
          chk("fifo_nonempty_at_pop", 64'(samp_q.size() != 0), 64'(1));
          if (samp_q.size() != 0) begin
            act_entry = samp_q.pop_front();
            chk("sample_writedata", 64'(io.bus_writedata), 64'(act_entry.data));
            gen(act_entry);
            in_txn     = 1'b1;
            polls_seen = 0;
          end
        end else begin
          chk("idle_bus_write", 64'(io.bus_write), 64'(0));
          chk("idle_bus_read", 64'(io.bus_read), 64'(0));
        end
      end

      chk("out_valid", 64'(io.out_valid), 64'(out_pending));
      if (out_pending) begin
        chk("out_data", 64'(io.out_data), 64'(exp_out));
        chk("out_error", 64'(io.out_error), 64'(exp_oerr));
      end
      chk("busy", 64'(busy), 64'(in_txn));
      chk("in_ready", 64'(io.in_ready), 64'(samp_q.size() != DEPTH));
      chk("timeout_err", 64'(timeout_err), 64'(sticky));

      expect_start = !in_txn && (samp_q.size() != 0);

      if (out_pending && io.out_ready) begin
        out_pending = 1'b0;
        in_txn      = 1'b0;
        last_out    = io.out_data;
        last_err    = io.out_error;
        last_polls  = polls_seen;
        acc_cnt++;
      end

      if (io.in_valid && io.in_ready) begin
        ps.data = io.in_data; ps.polls = cfg_polls; ps.err = cfg_err; ps.res = cfg_res;
        samp_q.push_back(ps);
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic push(input logic [W-1:0] d, input int polls, input logic err, input logic [W-1:0] res);
    int   c;
    logic ok;
    c = 0; ok = 1'b0;
    cfg_polls = polls; cfg_err = err; cfg_res = res;
    io.in_valid = 1'b1;
    io.in_data  = d;
    while (!ok && c < 100) begin
      @(negedge CLK);
      ok = io.in_ready;
      @(posedge CLK);
      #1;
      c++;
    end
    io.in_valid = 1'b0;
    chk("push_accepted", 64'(ok), 64'(1));
  endtask

  task automatic wait_acc(input int n, input int budget);
    int c;
    c = 0;
    while (acc_cnt < n && c < budget) begin
      @(posedge CLK);
      #1;
      c++;
    end
    chk("results_drained", 64'(acc_cnt >= n), 64'(1));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bus_write"}, 64'(io.bus_write), 64'(0));
    chk({tag, "_bus_read"}, 64'(io.bus_read), 64'(0));
    chk({tag, "_bus_address"}, 64'(io.bus_address), 64'(0));
    chk({tag, "_bus_writedata"}, 64'(io.bus_writedata), 64'(0));
    chk({tag, "_out_valid"}, 64'(io.out_valid), 64'(0));
    chk({tag, "_out_data"}, 64'(io.out_data), 64'(0));
    chk({tag, "_out_error"}, 64'(io.out_error), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_timeout_err"}, 64'(timeout_err), 64'(0));
    chk({tag, "_in_ready"}, 64'(io.in_ready), 64'(1));
  endtask

  initial begin
    int base;
    reset        = 1'b0;
    io.in_valid  = 1'b0;
    io.in_data   = '0;
    io.out_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk_all_zero("reset");
    reset  = 1'b1;
    chk_en = 1'b1;

    // single sample, done on the 3rd status read
    push(32'h0100_0000, 3, 1'b0, 32'h0080_0000);
    wait_acc(1, 50);
    chk("single_out_data", 64'(last_out), 64'h0080_0000);
    chk("single_out_error", 64'(last_err), 64'(0));
    chk("single_status_reads", 64'(last_polls), 64'(3));

    // FIFO fill with the result stalled, then 10 cycles of backpressure
    io.out_ready = 1'b0;
    base = acc_cnt;
    for (int i = 1; i <= 5; i++) push(W'(i * 32'h100), 1, 1'b0, W'(32'h1000 + i));
    chk("fifo_full_in_ready", 64'(io.in_ready), 64'(0));
    repeat (10) @(posedge CLK);
    #1;
    chk("hold_out_valid", 64'(io.out_valid), 64'(1));
    chk("hold_out_data", 64'(io.out_data), 64'h1001);
    chk("hold_busy", 64'(busy), 64'(1));
    chk("hold_no_read", 64'(io.bus_read), 64'(0));
    chk("hold_no_write", 64'(io.bus_write), 64'(0));
    io.out_ready = 1'b1;
    wait_acc(base + 5, 200);
    chk("fifo_last_result", 64'(last_out), 64'h1005);

    // core error flagged on the first poll
    push(32'hFFFF_FF00, 1, 1'b1, 32'h1234_5678);
    wait_acc(base + 6, 50);
    chk("core_err_out_data", 64'(last_out), 64'h1234_5678);
    chk("core_err_out_error", 64'(last_err), 64'(1));
    chk("core_err_status_reads", 64'(last_polls), 64'(1));
    chk("core_err_no_timeout", 64'(timeout_err), 64'(0));

    // status never done -> timeout
    push(32'h0000_00AA, 0, 1'b0, 32'h5555_5555);
    wait_acc(base + 7, 400);
    chk("timeout_out_data", 64'(last_out), 64'(0));
    chk("timeout_out_error", 64'(last_err), 64'(1));
    chk("timeout_status_reads", 64'(last_polls), 64'(255));
    chk("timeout_err_set", 64'(timeout_err), 64'(1));

    // timeout flag is sticky across a good transaction
    push(32'h0000_0042, 2, 1'b0, 32'hCAFE_0001);
    wait_acc(base + 8, 50);
    chk("after_tmo_out_data", 64'(last_out), 64'hCAFE_0001);
    chk("after_tmo_out_error", 64'(last_err), 64'(0));
    chk("timeout_err_sticky", 64'(timeout_err), 64'(1));

    // reset while polling, with a second sample waiting in the FIFO
    push(32'h0000_0077, 0, 1'b0, 32'h0);
    push(32'h0000_0088, 1, 1'b0, 32'h99);
    repeat (6) @(posedge CLK);
    #1;
    chk("pre_reset_polling", 64'(io.bus_read), 64'(1));
    chk("pre_reset_address", 64'(io.bus_address), 64'(A_STAT));
    chk_en = 1'b0;
    reset  = 1'b0;
    @(posedge CLK);
    #1;
    reset = 1'b1;
    chk_all_zero("mid_reset");
    clr_gen++;
    chk_en = 1'b1;
    repeat (20) @(posedge CLK);
    #1;
    chk("post_reset_idle", 64'(busy), 64'(0));

    // still functional after the abandoned transaction
    base = acc_cnt;
    push(32'h0000_0101, 1, 1'b0, 32'h0000_5A5A);
    wait_acc(base + 1, 50);
    chk("post_reset_out_data", 64'(last_out), 64'h5A5A);
    chk("post_reset_status_reads", 64'(last_polls), 64'(1));

    repeat (3) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
    $fatal(1);
  end

endmodule
